// File: rtl/aemb_ifetch_q.sv
// Instruction prefetch queue: WISHBONE classic fetch master feeding decode over valid/ready.
// Latency: word acked at edge E is at the queue head after E; a branch redirects the fetch at once, or after the pending ack when busy.
// Backpressure: ins_rdy_i low lets the queue fill; a new bus cycle starts only while a slot is free, so nothing is lost.
module aemb_ifetch_q #(
    parameter int              ISIZ = 32,
    parameter int              QDEP = 4,
    parameter logic [ISIZ-1:0] RSTV = '0
) (
    input  logic                   sys_clk_i,
    input  logic                   sys_rst_i,
    output logic [ISIZ-1:0]        iwb_adr_o,
    output logic                   iwb_stb_o,
    input  logic                   iwb_ack_i,
    input  logic [31:0]            iwb_dat_i,
    input  logic                   bra_i,
    input  logic [ISIZ-1:0]        bra_adr_i,
    output logic                   ins_vld_o,
    input  logic                   ins_rdy_i,
    output logic [31:0]            ins_dat_o,
    output logic [ISIZ-1:0]        ins_pc_o,
    output logic [$clog2(QDEP):0]  q_cnt_o
);

    localparam int PW = $clog2(QDEP);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] QFULL = CW'(QDEP);

    typedef enum logic {IDLE, BUSY} busState_t;

    busState_t       state, stateNext;
    logic [ISIZ-1:0] fpc, fpcNext;
    logic [ISIZ-1:0] busAdr, busAdrNext;
    logic [PW-1:0]   rdPtr, wrPtr;
    logic [CW-1:0]   cnt, cntNext;
    logic            dsc, dscNext;

    logic [31:0]     datQ [QDEP];
    logic [ISIZ-1:0] pcQ  [QDEP];

    logic busy, ack, push, pop, startCyc;

    assign busy = (state == BUSY);
    assign ack  = busy & iwb_ack_i;
    // A branch kills both the word landing this edge and any pop of the old stream.
    assign push = ack & ~dsc & ~bra_i;
    assign pop  = ins_vld_o & ins_rdy_i & ~bra_i;

    always_comb begin
        cntNext    = cnt;
        fpcNext    = fpc;
        dscNext    = dsc;
        stateNext  = state;
        busAdrNext = busAdr;
        startCyc   = 1'b0;

        if (bra_i)
            cntNext = '0;
        else if (push && !pop)
            cntNext = cnt + CW'(1);
        else if (pop && !push)
            cntNext = cnt - CW'(1);

        if (bra_i)
            fpcNext = {bra_adr_i[ISIZ-1:2], 2'b00};
        else if (push)
            fpcNext = fpc + ISIZ'(4);

        // Only one cycle can be outstanding, so one pending discard is enough.
        if (bra_i)
            dscNext = busy & ~iwb_ack_i;
        else if (ack)
            dscNext = 1'b0;

        if (!busy || ack) begin
            startCyc  = (cntNext < QFULL);
            stateNext = startCyc ? BUSY : IDLE;
        end

        // The bus address is frozen for the life of a cycle, even across a redirect.
        if (startCyc)
            busAdrNext = fpcNext;
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state  <= IDLE;
            fpc    <= RSTV;
            busAdr <= RSTV;
            rdPtr  <= '0;
            wrPtr  <= '0;
            cnt    <= '0;
            dsc    <= 1'b0;
        end else begin
            state  <= stateNext;
            fpc    <= fpcNext;
            busAdr <= busAdrNext;
            cnt    <= cntNext;
            dsc    <= dscNext;
            if (bra_i) begin
                rdPtr <= '0;
                wrPtr <= '0;
            end else begin
                if (push) wrPtr <= wrPtr + PW'(1);
                if (pop)  rdPtr <= rdPtr + PW'(1);
            end
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (push) begin
            datQ[wrPtr] <= iwb_dat_i;
            pcQ[wrPtr]  <= busAdr;
        end
    end

    assign iwb_adr_o = {busAdr[ISIZ-1:2], 2'b00};
    assign iwb_stb_o = busy;
    assign ins_vld_o = (cnt != '0);
    assign ins_dat_o = ins_vld_o ? datQ[rdPtr] : 32'h0;
    assign ins_pc_o  = ins_vld_o ? pcQ[rdPtr] : '0;
    assign q_cnt_o   = cnt;

endmodule

// File: tb/tb_aemb_ifetch_q.sv
// Bench for aemb_ifetch_q: WISHBONE slave model with programmable wait states and a pc scoreboard on the decode side.
module tb_aemb_ifetch_q;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [31:0] iwbAdr;
    logic        iwbStb;
    logic        iwbAck = 1'b0;
    logic [31:0] iwbDat = '0;
    logic        bra = 1'b0;
    logic [31:0] braAdr = '0;
    logic        insVld;
    logic        insRdy = 1'b0;
    logic [31:0] insDat;
    logic [31:0] insPc;
    logic [2:0]  qCnt;

    int nChk = 0;
    int nErr = 0;
    int waitStates = 0;
    int slvCnt = 0;
    logic [31:0] ackLog [$];
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    aemb_ifetch_q #(.ISIZ(32), .QDEP(4), .RSTV(32'h100)) dut (
        .sys_clk_i (clk),
        .sys_rst_i (rstN),
        .iwb_adr_o (iwbAdr),
        .iwb_stb_o (iwbStb),
        .iwb_ack_i (iwbAck),
        .iwb_dat_i (iwbDat),
        .bra_i     (bra),
        .bra_adr_i (braAdr),
        .ins_vld_o (insVld),
        .ins_rdy_i (insRdy),
        .ins_dat_o (insDat),
        .ins_pc_o  (insPc),
        .q_cnt_o   (qCnt)
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int ws, input logic rdy);
        rstN = 1'b0;
        bra = 1'b0;
        insRdy = rdy;
        waitStates = ws;
        repeat (2) @(negedge clk);
        ackLog.delete();
        sb.delete();
        #2 rstN = 1'b1;
        tick();
    endtask

    // Slave: acks after waitStates idle cycles; data is a function of the address.
    always @(negedge clk) begin
        if (!rstN) begin
            iwbAck = 1'b0;
            slvCnt = 0;
        end else if (iwbStb) begin
            if (slvCnt >= waitStates) begin
                iwbAck = 1'b1;
                iwbDat = memWord(iwbAdr);
                ackLog.push_back(iwbAdr);
                slvCnt = 0;
            end else begin
                iwbAck = 1'b0;
                slvCnt = slvCnt + 1;
            end
        end else begin
            iwbAck = 1'b0;
            slvCnt = 0;
        end
    end

    // Decode-side scoreboard: every accepted head must match the next expected pc.
    always @(negedge clk) begin
        if (rstN && insVld && insRdy && !bra) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_pc", insPc, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                chk("sb_pc", insPc, e);
                chk("sb_dat", insDat, memWord(e));
            end
        end
    end

    initial begin
        // Reset values, zero-wait fill with decode stalled
        rstN = 1'b0;
        #12;
        chk("rst_stb", {31'd0, iwbStb}, 32'd0);
        chk("rst_adr", iwbAdr, 32'h100);
        chk("rst_vld", {31'd0, insVld}, 32'd0);
        chk("rst_dat", insDat, 32'd0);
        chk("rst_pc", insPc, 32'd0);
        chk("rst_cnt", {29'd0, qCnt}, 32'd0);
        doReset(0, 1'b0);
        chk("first_stb", {31'd0, iwbStb}, 32'd1);
        chk("first_adr", iwbAdr, 32'h100);
        repeat (8) tick();
        chk("fill_cnt", {29'd0, qCnt}, 32'd4);
        chk("fill_stb", {31'd0, iwbStb}, 32'd0);
        chk("fill_headpc", insPc, 32'h100);
        chk("fill_acks", ackLog.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("fill_ackadr", ackLog[i], 32'h100 + 32'(4 * i));
            sb.push_back(32'h100 + 32'(4 * i));
        end

        // One pop from a full queue restarts the fetch
        insRdy = 1'b1;
        tick();
        insRdy = 1'b0;
        chk("pop_stb", {31'd0, iwbStb}, 32'd1);
        chk("pop_adr", iwbAdr, 32'h110);
        chk("pop_cnt", {29'd0, qCnt}, 32'd3);
        sb.push_back(32'h110);
        tick();
        chk("refill_cnt", {29'd0, qCnt}, 32'd4);
        chk("refill_stb", {31'd0, iwbStb}, 32'd0);
        insRdy = 1'b1;
        repeat (4) tick();
        insRdy = 1'b0;
        chk("drain_sb_empty", sb.size(), 32'd0);

        // Branch while a 3-wait cycle on 0x108 is pending
        doReset(3, 1'b0);
        for (int i = 0; i < 40 && !(iwbStb && iwbAdr == 32'h108); i++) tick();
        chk("b1_reach108", {31'd0, (iwbStb && iwbAdr == 32'h108)}, 32'd1);
        chk("b1_precnt", {29'd0, qCnt}, 32'd2);
        bra = 1'b1;
        braAdr = 32'h2002;
        tick();
        bra = 1'b0;
        chk("b1_cnt", {29'd0, qCnt}, 32'd0);
        chk("b1_vld", {31'd0, insVld}, 32'd0);
        chk("b1_adrheld", iwbAdr, 32'h108);
        for (int i = 0; i < 20 && iwbAdr == 32'h108; i++) tick();
        chk("b1_newadr", iwbAdr, 32'h2000);
        chk("b1_newstb", {31'd0, iwbStb}, 32'd1);
        chk("b1_dropped", {29'd0, qCnt}, 32'd0);
        chk("b1_lastack", ackLog[ackLog.size() - 1], 32'h108);
        for (int i = 0; i < 20 && !insVld; i++) tick();
        chk("b1_vld_to", {31'd0, insVld}, 32'd1);
        chk("b1_headpc", insPc, 32'h2000);
        chk("b1_headdat", insDat, memWord(32'h2000));

        // Branch coinciding with ack and pop in a zero-wait stream
        doReset(0, 1'b1);
        for (int i = 0; i < 5; i++) sb.push_back(32'h100 + 32'(4 * i));
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        chk("b2_stream_to", sb.size(), 32'd0);
        chk("b2_precnt", {29'd0, qCnt}, 32'd1);
        bra = 1'b1;
        braAdr = 32'h3000;
        tick();
        bra = 1'b0;
        chk("b2_cnt", {29'd0, qCnt}, 32'd0);
        chk("b2_vld", {31'd0, insVld}, 32'd0);
        chk("b2_adr", iwbAdr, 32'h3000);
        chk("b2_stb", {31'd0, iwbStb}, 32'd1);
        for (int i = 0; i < 3; i++) sb.push_back(32'h3000 + 32'(4 * i));
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        insRdy = 1'b0;
        chk("b2_target_to", sb.size(), 32'd0);

        // Two branches during one pending cycle: single discard, last target wins
        doReset(3, 1'b0);
        bra = 1'b1;
        braAdr = 32'h400;
        tick();
        braAdr = 32'h800;
        tick();
        bra = 1'b0;
        chk("b3_adrheld", iwbAdr, 32'h100);
        for (int i = 0; i < 20 && iwbAdr == 32'h100; i++) tick();
        chk("b3_newadr", iwbAdr, 32'h800);
        for (int i = 0; i < 20 && !insVld; i++) tick();
        chk("b3_vld_to", {31'd0, insVld}, 32'd1);
        chk("b3_headpc", insPc, 32'h800);
        chk("b3_cnt", {29'd0, qCnt}, 32'd1);
        chk("b3_ack0", ackLog[0], 32'h100);
        chk("b3_ack1", ackLog[1], 32'h800);

        // Asynchronous reset mid-cycle with two words queued
        doReset(3, 1'b0);
        for (int i = 0; i < 40 && qCnt != 3'd2; i++) tick();
        chk("ar_precnt", {29'd0, qCnt}, 32'd2);
        chk("ar_prestb", {31'd0, iwbStb}, 32'd1);
        #2 rstN = 1'b0;
        #1;
        chk("ar_stb", {31'd0, iwbStb}, 32'd0);
        chk("ar_adr", iwbAdr, 32'h100);
        chk("ar_vld", {31'd0, insVld}, 32'd0);
        chk("ar_dat", insDat, 32'd0);
        chk("ar_pc", insPc, 32'd0);
        chk("ar_cnt", {29'd0, qCnt}, 32'd0);
        doReset(3, 1'b0);
        chk("ar_restart_stb", {31'd0, iwbStb}, 32'd1);
        chk("ar_restart_adr", iwbAdr, 32'h100);
        for (int i = 0; i < 20 && !insVld; i++) tick();
        chk("ar_headpc", insPc, 32'h100);

        $display("CHECKS %0d ERRORS %0d", nChk, nErr);
        $finish;
    end

endmodule
